// File: rtl/song_sequencer_pkg.sv
// Shared definitions for the song sequencer: ROM entry layout, field widths and FSM states.
package song_defs;

  localparam int unsigned TYPE_BIT = 15;
  localparam int unsigned NOTE_MSB = 14;
  localparam int unsigned NOTE_LSB = 9;
  localparam int unsigned DUR_MSB  = 8;
  localparam int unsigned DUR_LSB  = 3;

  localparam logic TYPE_NOTE = 1'b0;
  localparam logic TYPE_ADV  = 1'b1;

  localparam int unsigned NOTE_W = 6;
  localparam int unsigned DUR_W  = 6;

  typedef enum logic [2:0] {
    StFetch,
    StData,
    StEmit,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/song_sequencer_if.sv
// Note-event bus from the sequencer to the voice distributor.
interface song_sequencer_if;

  logic                       load_new_note;
  logic [song_defs::NOTE_W-1:0] note_to_load;
  logic [song_defs::DUR_W-1:0]  duration_to_load;
  logic                       song_done;

  modport master (
    output load_new_note,
    output note_to_load,
    output duration_to_load,
    output song_done
  );

  modport slave (
    input load_new_note,
    input note_to_load,
    input duration_to_load,
    input song_done
  );

endinterface

// File: rtl/song_rom.sv
// Song storage: four songs of 32 entries, one-cycle registered read, with built-in contents.
module song_rom #(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned SONG_W = 2
) (
  input  logic                    clk,
  input  logic [SONG_W+IDX_W-1:0] addr,
  output logic [15:0]             data
);

  localparam int unsigned Depth = 2**(SONG_W+IDX_W);

  // End marker: type = advance, duration = 0.
  localparam logic [15:0] EntEnd = 16'h8000;

  logic [15:0] mem [Depth];

  initial begin
    for (int unsigned i = 0; i < Depth; i++) mem[i] = EntEnd;
    mem[0] = {1'b0, 6'd20, 6'd8, 3'b000};
    mem[1] = {1'b0, 6'd24, 6'd8, 3'b000};
    mem[2] = {1'b0, 6'd27, 6'd8, 3'b000};
    mem[3] = {1'b1, 6'd0,  6'd8, 3'b000};
    mem[4] = EntEnd;
  end

  always_ff @(posedge clk) begin
    data <= mem[addr];
  end

endmodule

// File: rtl/song_sequencer.sv
// Walks the selected song in the ROM, issuing note-event pulses and beat-counted time advances.
module song_sequencer
  import song_defs::*;
#(
  parameter int unsigned IDX_W  = 5,
  parameter int unsigned SONG_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    play,
  input  logic                    beat,
  input  logic [SONG_W-1:0]       song,
  song_sequencer_if.master        note_bus,
  output logic [SONG_W+IDX_W-1:0] rom_addr,
  input  logic [15:0]             rom_data
);

  localparam logic [IDX_W-1:0] IdxMax = {IDX_W{1'b1}};

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DUR_W-1:0]    cnt_q, cnt_d;
  logic [SONG_W-1:0]   song_q;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [DUR_W-1:0]    dur_q, dur_d;

  logic                song_change;
  logic                last_idx;
  logic                entry_type;
  logic [NOTE_W-1:0]   entry_note;
  logic [DUR_W-1:0]    entry_dur;
  logic [2:0]          unused_entry_bits;

  assign song_change       = (song != song_q);
  assign last_idx          = (idx_q == IdxMax);
  assign entry_type        = rom_data[TYPE_BIT];
  assign entry_note        = rom_data[NOTE_MSB:NOTE_LSB];
  assign entry_dur         = rom_data[DUR_MSB:DUR_LSB];
  assign unused_entry_bits = rom_data[2:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    note_d  = note_q;
    dur_d   = dur_q;

    unique case (state_q)
      StFetch: begin
        if (play) state_d = StData;
      end
      StData: begin
        // DATA always completes so the entry read from ROM is never lost to a pause.
        if (entry_type == TYPE_NOTE) begin
          note_d  = entry_note;
          dur_d   = entry_dur;
          state_d = StEmit;
        end else if (entry_dur == '0) begin
          state_d = StDone;
        end else begin
          cnt_d   = entry_dur;
          state_d = StWait;
        end
      end
      StEmit: begin
        if (last_idx) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StFetch;
        end
      end
      StWait: begin
        if (play && beat) begin
          if (cnt_q == DUR_W'(1)) begin
            if (last_idx) begin
              state_d = StDone;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = StFetch;
            end
          end
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (song_change) begin
      state_d = StFetch;
      idx_d   = '0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      idx_q   <= '0;
      cnt_q   <= '0;
      song_q  <= song;
      note_q  <= '0;
      dur_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      song_q  <= song;
      note_q  <= note_d;
      dur_q   <= dur_d;
    end
  end

  // A song change seen during EMIT suppresses the pulse in that same cycle.
  assign note_bus.load_new_note    = (state_q == StEmit) && !song_change;
  assign note_bus.note_to_load     = note_q;
  assign note_bus.duration_to_load = dur_q;
  assign note_bus.song_done        = (state_q == StDone);
  assign rom_addr                  = {song_q, idx_q};

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer: directed scenarios plus randomized songs and beat/play
// schedules, compared against an entry-walking timeline model.
module tb_song_sequencer;
  import song_defs::*;

  localparam int N = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        play = 1'b0;
  logic        beat = 1'b0;
  logic [1:0]  song = 2'd0;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;

  logic [15:0] mem [128];

  bit play_s [N];
  bit beat_s [N];
  int exp_load [N];
  int exp_note [N];
  int exp_dur [N];
  int exp_done [N];
  int exp_addr [N];
  bit addr_chk [N];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rom_data <= mem[rom_addr];

  song_sequencer_if nb ();

  song_sequencer #(
    .IDX_W (5),
    .SONG_W(2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .play    (play),
    .beat    (beat),
    .song    (song),
    .note_bus(nb),
    .rom_addr(rom_addr),
    .rom_data(rom_data)
  );

  function automatic logic [15:0] ent_note(input int n, input int d);
    logic [5:0] nn, dd;
    nn = n[5:0];
    dd = d[5:0];
    return {1'b0, nn, dd, 3'b000};
  endfunction

  function automatic logic [15:0] ent_adv(input int d);
    logic [5:0] dd;
    dd = d[5:0];
    return {1'b1, 6'd0, dd, 3'b000};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Timeline model: walk entries, placing each fetch, pulse and advance on the cycle axis.
  task automatic model(input int sg);
    int t, idx, done_from, c, k, d;
    logic [15:0] e;
    for (int j = 0; j < N; j++) begin
      exp_load[j] = 0; exp_note[j] = 0; exp_dur[j] = 0; addr_chk[j] = 0; exp_addr[j] = 0;
    end
    done_from = N;
    t = 0;
    idx = 0;
    while (t < N) begin
      while (t < N && !play_s[t]) t++;
      if (t >= N) break;
      addr_chk[t] = 1;
      exp_addr[t] = sg * 32 + idx;
      e = mem[sg * 32 + idx];
      if (!e[15]) begin
        if (t + 2 < N) exp_load[t + 2] = 1;
        for (int j = t + 2; j < N; j++) begin
          exp_note[j] = int'(e[14:9]);
          exp_dur[j]  = int'(e[8:3]);
        end
        if (idx == 31) begin
          done_from = t + 3;
          break;
        end
        idx++;
        t = t + 3;
      end else if (e[8:3] == 6'd0) begin
        done_from = t + 2;
        break;
      end else begin
        d = int'(e[8:3]);
        k = 0;
        c = t + 2;
        while (c < N) begin
          if (beat_s[c] && play_s[c]) begin
            k++;
            if (k == d) break;
          end
          c++;
        end
        if (c >= N) break;
        if (idx == 31) begin
          done_from = c + 1;
          break;
        end
        idx++;
        t = c + 1;
      end
    end
    for (int j = 0; j < N; j++) exp_done[j] = (j >= done_from) ? 1 : 0;
  endtask

  task automatic run(input int sg, input string tag);
    model(sg);
    song  = 2'(sg);
    play  = 1'b0;
    beat  = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < N; c++) begin
      play = play_s[c];
      beat = beat_s[c];
      @(negedge clk);
      check($sformatf("%s load c%0d", tag, c), 32'(nb.load_new_note), exp_load[c]);
      check($sformatf("%s done c%0d", tag, c), 32'(nb.song_done), exp_done[c]);
      check($sformatf("%s note c%0d", tag, c), 32'(nb.note_to_load), exp_note[c]);
      check($sformatf("%s dur c%0d", tag, c), 32'(nb.duration_to_load), exp_dur[c]);
      if (addr_chk[c]) check($sformatf("%s addr c%0d", tag, c), 32'(rom_addr), exp_addr[c]);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = ent_adv(0);

    // Chord then eight-beat rest then end.
    mem[0] = ent_note(20, 8);
    mem[1] = ent_note(24, 8);
    mem[2] = ent_note(27, 8);
    mem[3] = ent_adv(8);
    mem[4] = ent_adv(0);
    for (int c = 0; c < N; c++) begin
      play_s[c] = 1'b1;
      beat_s[c] = (c % 5 == 3);
    end
    run(0, "chord");

    // Beat coinciding with DATA of an advance must not count.
    mem[96] = ent_adv(3);
    mem[97] = ent_note(5, 1);
    mem[98] = ent_adv(0);
    for (int c = 0; c < N; c++) begin
      play_s[c] = 1'b1;
      beat_s[c] = (c == 1 || c == 3 || c == 5 || c == 7);
    end
    run(3, "adv_data_beat");

    // Pause mid-WAIT after one of four beats; beats while paused are ignored.
    mem[32] = ent_adv(4);
    mem[33] = ent_note(10, 2);
    mem[34] = ent_adv(0);
    for (int c = 0; c < N; c++) begin
      play_s[c] = !(c >= 5 && c <= 20);
      beat_s[c] = (c == 4 || c == 6 || c == 8 || c == 10 || c == 12 || c == 14 ||
                   c == 25 || c == 30 || c == 35);
    end
    run(1, "pause");

    // Full song of notes with no end marker: index must stop at 31, never wrap.
    for (int i = 0; i < 32; i++) mem[64 + i] = ent_note(i + 1, i + 2);
    for (int c = 0; c < N; c++) begin
      play_s[c] = 1'b1;
      beat_s[c] = 1'b0;
    end
    run(2, "all_notes");
    check("all_notes final done", 32'(nb.song_done), 32'd1);

    // Song change during EMIT drops the pulse and restarts at idx 0 of the new song.
    mem[64] = ent_adv(0);
    song  = 2'd0;
    play  = 1'b1;
    beat  = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    song = 2'd2;
    @(negedge clk);
    check("chg_emit load", 32'(nb.load_new_note), 32'd0);
    step();
    @(negedge clk);
    check("chg_emit addr", 32'(rom_addr), 32'h40);
    check("chg_emit load next", 32'(nb.load_new_note), 32'd0);
    check("chg_emit done", 32'(nb.song_done), 32'd0);
    step();
    step();
    @(negedge clk);
    check("chg_done reached", 32'(nb.song_done), 32'd1);
    step();
    song = 2'd0;
    step();
    @(negedge clk);
    check("chg_done cleared", 32'(nb.song_done), 32'd0);
    check("chg_done addr", 32'(rom_addr), 32'h00);
    step();
    step();
    @(negedge clk);
    check("chg_done pulse", 32'(nb.load_new_note), 32'd1);
    check("chg_done note", 32'(nb.note_to_load), 32'd20);

    // Reset while waiting with counter at 5 clears outputs and refetches idx 0.
    mem[32] = ent_note(33, 5);
    mem[33] = ent_adv(9);
    song  = 2'd1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst pre pulse", 32'(nb.load_new_note), 32'd1);
    check("rst pre note", 32'(nb.note_to_load), 32'd33);
    for (int c = 3; c < 10; c++) begin
      step();
      beat = (c >= 5 && c <= 8);
    end
    step();
    beat  = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    check("rst load", 32'(nb.load_new_note), 32'd0);
    check("rst note", 32'(nb.note_to_load), 32'd0);
    check("rst dur", 32'(nb.duration_to_load), 32'd0);
    check("rst done", 32'(nb.song_done), 32'd0);
    check("rst addr", 32'(rom_addr), 32'h20);
    step();
    step();
    @(negedge clk);
    check("rst refetch pulse", 32'(nb.load_new_note), 32'd1);
    check("rst refetch note", 32'(nb.note_to_load), 32'd33);
    check("rst refetch dur", 32'(nb.duration_to_load), 32'd5);

    // Randomized songs and beat/play schedules.
    for (int it = 0; it < 6; it++) begin
      int r;
      logic [15:0] e;
      for (int i = 0; i < 128; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 4) e = ent_adv(0);
        else if (r < 70) e = ent_note(int'($urandom_range(0, 63)), int'($urandom_range(1, 63)));
        else e = ent_adv(int'($urandom_range(1, 4)));
        e[2:0] = 3'($urandom_range(0, 7));
        mem[i] = e;
      end
      for (int c = 0; c < N; c++) begin
        play_s[c] = ($urandom_range(0, 7) != 0);
        beat_s[c] = ($urandom_range(0, 3) == 0);
      end
      run(int'($urandom_range(0, 3)), $sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
